rr_hold_arb: RTL
================

# rr_hold_arb

Registered round-robin arbiter with grant hold and hold-time limit. It shares one resource among up to five requesters, replacing fixed-priority selection with fair rotation. A grant is held across a multi-cycle transaction until the owner releases it or a hold limit expires. It sits between the requester ports and the shared datapath and drives that datapath's select and enable.

## Interface
- N, 5, number of requesters (2..8)
- MAX_HOLD, 16, maximum cycles one grant may stay asserted; 0 disables the limit
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-low reset
- req  input  N  request per requester, level; bit i = requester i
- done  input  N  owner's end-of-transaction strobe, 1 cycle; ignored for non-owners
- grt  output  N  registered one-hot grant; all-zero when idle
- grt_vld  output  1  OR of grt
- grt_id  output  3  binary index of current owner; 0 when grt_vld=0
- timeout  output  1  one-cycle pulse: grant revoked by hold limit

## Operation
- State: IDLE, GRANT.
- Registers: state, grt, grt_id, rotation pointer ptr (0..N-1), hold counter cnt of width clog2(MAX_HOLD+1), timeout.
- IDLE, any req bit set:
  - Winner = first set req bit searching ptr, ptr+1, …, N-1, 0, …, ptr-1.
  - At the next edge: grt = onehot(winner), grt_id = winner, ptr = (winner+1) mod N (wraps N-1 -> 0), cnt = 0, state = GRANT.
- IDLE, req == 0: outputs stay zero and ptr holds.
- GRANT: the owner is o = grt_id. Release condition, sampled each edge:
  - (a) req[o] = 0, or
  - (b) done[o] = 1, or
  - (c) MAX_HOLD != 0 and cnt == MAX_HOLD-1.
- On release: at that edge grt = 0, grt_id = 0, cnt = 0, and state = IDLE. timeout = 1 for that one cycle only if (c) is true and neither (a) nor (b) is.
- Otherwise cnt increments, saturating at MAX_HOLD-1.
- Fairness:
  - There is always at least one idle cycle between grants.
  - A requester still holding req after release is considered only in rotation order. With all N requesting continuously, the grant order is 0,1,…,N-1,0,…
- req and done bits of non-owners never affect the current grant.
- req bits at index >= N do not exist. grt_id upper bits are 0 when N < 8.

## Timing
- Reset (rst=0, asynchronous, any time): grt = 0, grt_vld = 0, grt_id = 0, timeout = 0, ptr = 0, cnt = 0, state = IDLE.
  - Reset mid-grant drops grt immediately, without waiting for a clock edge.
  - Rotation restarts from requester 0.
- Request-to-grant latency: req sampled high at edge E in IDLE -> grt high after edge E.
  - Worst case while another requester owns the resource: the current hold (at most MAX_HOLD cycles), then 1 idle cycle, then up to N-1 other grants of the same length.
- Release latency: release sampled at edge E -> grt = 0 after E. The next grant can appear at edge E+1 at the earliest.
- Maximum grant length: exactly MAX_HOLD cycles of grt high when neither req drop nor done occurs.
- timeout is high during the first idle cycle after a forced release, then returns to 0.
- Simultaneous events:
  - done and the limit on the same edge: normal release, no timeout.
  - req drop and done together: normal release.
  - New req arriving during GRANT: waits, no effect on the current grant.
  - All outputs change only on rising clk or on asserted rst.

## Test plan
- Reset mid-grant: grt = 5'b00100 held, rst driven low between edges -> grt = 0 and grt_id = 0 immediately. After release, with req = 5'b11111, the next grant is 5'b00001.
- Rotation, N=5, MAX_HOLD=16, req = 5'b11111 held, done pulsed on the 3rd grant cycle each time -> grant sequence 0,1,2,3,4,0. Each grant lasts 3 cycles with 1 idle cycle between grants. timeout never set.
- Pointer skip and wrap: last grant was to 3, then req = 5'b00101 -> grant to 0 (search 4,0). Next grant with the same req -> 2.
- Hold limit, MAX_HOLD=4: req = 5'b00010 held, done never asserted -> grt = 5'b00010 for exactly 4 cycles, then grt = 0 with timeout = 1 for one cycle. Regrant to 1 follows on the next edge.
- Limit vs done collision, MAX_HOLD=4: done[1] asserted on the 4th grant cycle -> release with timeout = 0. Owner drops req on the 2nd cycle -> release after 2 cycles, timeout = 0.
- Non-owner noise: owner 2 granted, done[0] and done[4] pulsed, req[3] toggled -> grt stays 5'b00100 until done[2].

Source files
------------

// File: rtl/rr_hold_arb.sv
// Round-robin arbiter with registered one-hot grant, grant hold until release,
// and an optional hold-time limit that forces release with a timeout pulse.
module rr_hold_arb #(
  parameter int N        = 5,
  parameter int MAX_HOLD = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic [N-1:0] done,
  output logic [N-1:0] grt,
  output logic         grt_vld,
  output logic [2:0]   grt_id,
  output logic         timeout
);

  localparam int CW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam logic [CW-1:0] CLIM    = (MAX_HOLD > 0) ? CW'(MAX_HOLD - 1) : '0;
  localparam logic          HAS_LIM = (MAX_HOLD != 0);

  typedef enum logic {IDLE, GRANT} state_e;

  state_e         state_q, state_d;
  logic [N-1:0]   grt_q, grt_d;
  logic [2:0]     id_q, id_d;
  logic [2:0]     ptr_q, ptr_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           to_q, to_d;

  logic [3:0]     idx;
  logic [2:0]     win;
  logic           own_req, own_done, at_lim;

  // Scan from the far end of the rotation back to ptr so the last hit is the
  // first set bit at or after ptr.
  always_comb begin
    win = '0;
    idx = '0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = {1'b0, ptr_q} + 4'(k);
      if (idx >= 4'(N)) idx = idx - 4'(N);
      if (req[idx[2:0]]) win = idx[2:0];
    end
  end

  // Owner's req/done picked through the one-hot grant; non-owners are masked.
  assign own_req  = |(req & grt_q);
  assign own_done = |(done & grt_q);
  assign at_lim   = HAS_LIM && (cnt_q == CLIM);

  always_comb begin
    state_d = state_q;
    grt_d   = grt_q;
    id_d    = id_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    to_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (|req) begin
          grt_d   = N'(1) << win;
          id_d    = win;
          ptr_d   = (win == 3'(N - 1)) ? 3'd0 : win + 3'd1;
          cnt_d   = '0;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (!own_req || own_done || at_lim) begin
          grt_d   = '0;
          id_d    = '0;
          cnt_d   = '0;
          state_d = IDLE;
          to_d    = at_lim && own_req && !own_done;
        end else if (cnt_q != CLIM) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      grt_q   <= '0;
      id_q    <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      grt_q   <= grt_d;
      id_q    <= id_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      to_q    <= to_d;
    end
  end

  assign grt     = grt_q;
  assign grt_vld = |grt_q;
  assign grt_id  = id_q;
  assign timeout = to_q;

endmodule
